// File: rtl/rr_dispatch_1to4.sv
// One-to-four round-robin dispatcher with a one-entry registered output stage.
// Optional per-lane saturating drain counters when RR_DISPATCH_STATS_EN is defined.
module rr_dispatch_1to4 #(
  parameter int unsigned DW = 8
`ifdef RR_DISPATCH_STATS_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic          ck,
  input  logic          nrst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic [3:0]    lane_en,
  output logic [3:0]    q_valid,
  input  logic [3:0]    q_ready,
  output logic [DW-1:0] q_data,
  output logic [1:0]    rr_ptr
`ifdef RR_DISPATCH_STATS_EN
  ,
  output logic [4*CNT_W-1:0] lane_cnt
`endif
);

  logic          drain;
  logic          accept;
  logic          sel_found;
  logic [1:0]    sel_idx;
  logic [1:0]    cand;
  logic [3:0]    sel_onehot;

  // Only the latched target lane's ready matters; q_valid is one-hot or zero.
  assign drain   = |(q_valid & q_ready);
  assign i_ready = (lane_en != 4'b0000) && ((q_valid == 4'b0000) || drain);
  assign accept  = i_valid && i_ready;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!sel_found && lane_en[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_onehot = 4'b0001 << sel_idx;
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      q_valid <= 4'b0000;
      q_data  <= '0;
      rr_ptr  <= 2'd0;
    end else if (accept) begin
      q_valid <= sel_onehot;
      q_data  <= i_data;
      rr_ptr  <= sel_idx + 2'd1;
    end else if (drain) begin
      q_valid <= 4'b0000;
    end
  end

`ifdef RR_DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];

  for (genvar n = 0; n < 4; n++) begin : g_stats
    always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
        cnt_q[n] <= '0;
      end else if (q_valid[n] && q_ready[n] && (cnt_q[n] != {CNT_W{1'b1}})) begin
        cnt_q[n] <= cnt_q[n] + 1'b1;
      end
    end
    assign lane_cnt[n*CNT_W +: CNT_W] = cnt_q[n];
  end
`endif

endmodule

// File: tb/tb_rr_dispatch_1to4.sv
// Directed self-checking bench for rr_dispatch_1to4; exercises stats when
// RR_DISPATCH_STATS_EN is defined (counters built with CNT_W=2).
module tb_rr_dispatch_1to4;

  logic       ck = 1'b0;
  logic       nrst;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_data;
  logic [3:0] lane_en;
  logic [3:0] q_valid;
  logic [3:0] q_ready;
  logic [7:0] q_data;
  logic [1:0] rr_ptr;
`ifdef RR_DISPATCH_STATS_EN
  logic [7:0] lane_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 ck = ~ck;

  rr_dispatch_1to4 #(
    .DW(8)
`ifdef RR_DISPATCH_STATS_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .ck      (ck),
    .nrst    (nrst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .lane_en (lane_en),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .q_data  (q_data),
    .rr_ptr  (rr_ptr)
`ifdef RR_DISPATCH_STATS_EN
    ,
    .lane_cnt(lane_cnt)
`endif
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; i_valid = 1'b1; i_data = 8'hEE; lane_en = 4'b1111; q_ready = 4'b1111;
    tick(); tick();
    tests++;
    if ({q_valid, rr_ptr, q_data, i_ready} !== {4'b0000, 2'd0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL reset: q_valid=%b rr_ptr=%0d q_data=%h i_ready=%b, want 0000 0 00 1",
               q_valid, rr_ptr, q_data, i_ready);
    end
    i_valid = 1'b0;
    nrst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      i_data = 8'hA0 + 8'(k); i_valid = 1'b1;
      tick();
      tests++;
      if ({q_valid, q_data, rr_ptr} !== {4'(1 << k), 8'hA0 + 8'(k), 2'(k + 1)}) begin
        fails++;
        $display("FAIL rr_seq[%0d]: q_valid=%b q_data=%h rr_ptr=%0d, want %b %h %0d", k,
                 q_valid, q_data, rr_ptr, 4'(1 << k), 8'hA0 + 8'(k), 2'(k + 1));
      end
    end
    i_valid = 1'b0;
    tick();
    tests++;
    if ({q_valid, q_data} !== {4'b0000, 8'hA3}) begin
      fails++;
      $display("FAIL drain_only: q_valid=%b q_data=%h, want 0000 a3", q_valid, q_data);
    end
  endtask

  task automatic test_masking();
    logic [3:0] exp_v [3];
    logic [1:0] exp_p [3];
    exp_v[0] = 4'b0001; exp_v[1] = 4'b0100; exp_v[2] = 4'b0001;
    exp_p[0] = 2'd1;    exp_p[1] = 2'd3;    exp_p[2] = 2'd1;
    lane_en = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      i_data = 8'h10 + 8'(k); i_valid = 1'b1;
      tick();
      tests++;
      if ({q_valid, q_data, rr_ptr} !== {exp_v[k], 8'h10 + 8'(k), exp_p[k]}) begin
        fails++;
        $display("FAIL mask[%0d]: q_valid=%b q_data=%h rr_ptr=%0d, want %b %h %0d", k,
                 q_valid, q_data, rr_ptr, exp_v[k], 8'h10 + 8'(k), exp_p[k]);
      end
    end
    i_valid = 1'b0;
    tick();
    lane_en = 4'b0000; i_valid = 1'b1; i_data = 8'h13;
    #1;
    tests++;
    if (i_ready !== 1'b0) begin
      fails++;
      $display("FAIL mask_zero_ready: i_ready=%b, want 0", i_ready);
    end
    tick();
    tests++;
    if ({q_valid, rr_ptr} !== {4'b0000, 2'd1}) begin
      fails++;
      $display("FAIL mask_zero_accept: q_valid=%b rr_ptr=%0d, want 0000 1", q_valid, rr_ptr);
    end
    i_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    lane_en = 4'b1111; q_ready = 4'b0000;
    i_data = 8'h55; i_valid = 1'b1;
    tick();
    i_data = 8'h66;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if ({i_ready, q_valid, q_data} !== {1'b0, 4'b0010, 8'h55}) begin
        fails++;
        $display("FAIL hold[%0d]: i_ready=%b q_valid=%b q_data=%h, want 0 0010 55", k,
                 i_ready, q_valid, q_data);
      end
      tick();
    end
    q_ready = 4'b0010;
    #1;
    tests++;
    if (i_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain_ready: i_ready=%b, want 1", i_ready);
    end
    tick();
    tests++;
    if ({q_valid, q_data, rr_ptr} !== {4'b0100, 8'h66, 2'd3}) begin
      fails++;
      $display("FAIL drain_accept: q_valid=%b q_data=%h rr_ptr=%0d, want 0100 66 3",
               q_valid, q_data, rr_ptr);
    end
    i_valid = 1'b0; q_ready = 4'b1111;
    tick();
  endtask

  task automatic test_mask_change();
    q_ready = 4'b0000; i_data = 8'h77; i_valid = 1'b1;
    tick();
    i_valid = 1'b0; lane_en = 4'b0001; q_ready = 4'b0111;
    tick();
    tests++;
    if ({q_valid, q_data} !== {4'b1000, 8'h77}) begin
      fails++;
      $display("FAIL mask_change_hold: q_valid=%b q_data=%h, want 1000 77", q_valid, q_data);
    end
    q_ready = 4'b1000;
    tick();
    tests++;
    if (q_valid !== 4'b0000) begin
      fails++;
      $display("FAIL mask_change_drain: q_valid=%b, want 0000", q_valid);
    end
    i_data = 8'h88; i_valid = 1'b1; q_ready = 4'b0000;
    tick();
    tests++;
    if ({q_valid, q_data, rr_ptr} !== {4'b0001, 8'h88, 2'd1}) begin
      fails++;
      $display("FAIL mask_change_next: q_valid=%b q_data=%h rr_ptr=%0d, want 0001 88 1",
               q_valid, q_data, rr_ptr);
    end
    i_valid = 1'b0; q_ready = 4'b1111;
    tick();
  endtask

  task automatic test_async_reset();
    lane_en = 4'b1111; q_ready = 4'b0000; i_data = 8'h99; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tests++;
    if ({q_valid, rr_ptr} !== {4'b0010, 2'd2}) begin
      fails++;
      $display("FAIL pre_async: q_valid=%b rr_ptr=%0d, want 0010 2", q_valid, rr_ptr);
    end
    #2 nrst = 1'b0;
    #1;
    tests++;
    if ({q_valid, rr_ptr, q_data} !== {4'b0000, 2'd0, 8'h00}) begin
      fails++;
      $display("FAIL async_reset: q_valid=%b rr_ptr=%0d q_data=%h, want 0000 0 00",
               q_valid, rr_ptr, q_data);
    end
    tick();
    nrst = 1'b1; q_ready = 4'b1111; i_data = 8'hAB; i_valid = 1'b1;
    tick();
    tests++;
    if ({q_valid, q_data, rr_ptr} !== {4'b0001, 8'hAB, 2'd1}) begin
      fails++;
      $display("FAIL post_reset: q_valid=%b q_data=%h rr_ptr=%0d, want 0001 ab 1",
               q_valid, q_data, rr_ptr);
    end
    i_valid = 1'b0;
    tick();
  endtask

`ifdef RR_DISPATCH_STATS_EN
  task automatic test_stats();
    nrst = 1'b0;
    #1;
    tests++;
    if (lane_cnt !== 8'h00) begin
      fails++;
      $display("FAIL stats_reset: lane_cnt=%h, want 00", lane_cnt);
    end
    tick();
    nrst = 1'b1; lane_en = 4'b0001; q_ready = 4'b1111; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_data = 8'hC0 + 8'(k);
      tick();
      // k-th edge drains word k-1 (if any), so k drains counted so far
      if (k == 2) begin
        tests++;
        if (lane_cnt !== 8'h02) begin
          fails++;
          $display("FAIL stats_mid: lane_cnt=%h, want 02", lane_cnt);
        end
      end
    end
    i_valid = 1'b0;
    tick();
    tests++;
    if (lane_cnt !== 8'h03) begin
      fails++;
      $display("FAIL stats_sat: lane_cnt=%h, want 03", lane_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_masking();
    test_backpressure();
    test_mask_change();
    test_async_reset();
`ifdef RR_DISPATCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
